// File: rtl/fp12_pkg.sv
// Shared definitions for the 12-bit floating-point add path:
// field positions, special encodings and the sequencer state type.
package fp12_pkg;

    localparam int EW       = 4;
    localparam int MW       = 7;
    localparam int EXP_MSB  = 10;
    localparam int EXP_LSB  = 7;
    localparam int FRAC_MSB = 6;

    localparam logic [11:0]   FP12_ZERO = 12'h000;
    localparam logic [11:0]   FP12_SAT  = 12'h7FF;
    localparam logic [EW-1:0] EXP_MAX   = 4'hF;
    localparam logic [EW-1:0] EXP_ONE   = 4'h1;

    typedef enum logic [1:0] {
        IDLE,
        ORDER,
        EXEC,
        RESP
    } state_t;

endpackage

// File: rtl/fp12_add_core.sv
// Combinational magnitude adder for the 12-bit float format.
// The caller guarantees exp(x) >= exp(y). The smaller operand is aligned by
// right shift and the result is truncated. carry reports a mantissa carry-out,
// which bumps the exponent; the caller decides whether that overflowed.
module fp12_add_core
    import fp12_pkg::*;
(
    input  logic [10:0] x,
    input  logic [10:0] y,
    output logic [10:0] sum,
    output logic        carry
);

    logic [EW-1:0] ex;
    logic [EW-1:0] ey;
    logic [EW-1:0] ex_inc;
    logic [EW-1:0] shamt;
    logic [MW:0]   mx;
    logic [MW:0]   my;
    logic [MW+1:0] total;

    assign ex     = x[EXP_MSB:EXP_LSB];
    assign ey     = y[EXP_MSB:EXP_LSB];
    assign ex_inc = ex + EXP_ONE;
    assign shamt  = ex - ey;

    // Align y to x, add the mantissas with hidden ones, renormalise on carry.
    always_comb begin
        mx    = {1'b1, x[FRAC_MSB:0]};
        my    = {1'b1, y[FRAC_MSB:0]} >> shamt;
        total = {1'b0, mx} + {1'b0, my};
        carry = total[MW+1];
        if (carry) begin
            sum = {ex_inc, total[MW:1]};
        end else begin
            sum = {ex, total[MW-1:0]};
        end
    end

endmodule

// File: rtl/fp12_add_arbiter.sv
// Two-port round-robin front end for the shared fp12 adder.
// Accepts one operand pair at a time, orders it so the larger magnitude
// feeds the core's x input, handles zero operands and exponent overflow,
// and holds the registered result until the consumer takes it.
// Optional build macro FP12_ARB_STATS_EN adds per-port completion and
// overflow counters.
module fp12_add_arbiter
    import fp12_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  in_valid,
    output logic [1:0]  in_ready,
    input  logic [11:0] in_a0,
    input  logic [11:0] in_b0,
    input  logic [11:0] in_a1,
    input  logic [11:0] in_b1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out_data,
    output logic        out_id,
    output logic        out_ovf
`ifdef FP12_ARB_STATS_EN
    ,
    output logic [7:0]  cnt_done0,
    output logic [7:0]  cnt_done1,
    output logic [7:0]  cnt_ovf
`endif
);

    state_t      state_q;
    state_t      state_d;
    logic        last_grant;
    logic        win_id;
    logic        accept;
    logic        id_q;
    logic [10:0] x_q;
    logic [10:0] y_q;
    logic [10:0] sel_a;
    logic [10:0] sel_b;
    logic [10:0] core_sum;
    logic        core_carry;
    logic [11:0] res_data;
    logic        res_ovf;
    logic        unused_sign_bits;

    // Input sign bits carry no meaning for this unsigned-magnitude path.
    assign unused_sign_bits = ^{in_a0[11], in_b0[11], in_a1[11], in_b1[11]};

    fp12_add_core u_core (
        .x     (x_q),
        .y     (y_q),
        .sum   (core_sum),
        .carry (core_carry)
    );

    // Round robin: with both ports asking, favour the one not served last.
    always_comb begin
        if (in_valid == 2'b11) begin
            win_id = ~last_grant;
        end else begin
            win_id = in_valid[1];
        end
    end

    assign sel_a  = win_id ? in_a1[10:0] : in_a0[10:0];
    assign sel_b  = win_id ? in_b1[10:0] : in_b0[10:0];
    assign accept = (state_q == IDLE) && (|in_valid);

    // Result selection: zero operands bypass the core, exp-15 carry saturates.
    always_comb begin
        res_data = FP12_ZERO;
        res_ovf  = 1'b0;
        if (x_q == '0) begin
            res_data = FP12_ZERO;
        end else if (y_q == '0) begin
            res_data = {1'b0, x_q};
        end else if (core_carry && (x_q[EXP_MSB:EXP_LSB] == EXP_MAX)) begin
            res_data = FP12_SAT;
            res_ovf  = 1'b1;
        end else begin
            res_data = {1'b0, core_sum};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the handshake outputs, which depend only on state and inputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 2'b00;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (|in_valid) begin
                    in_ready = win_id ? 2'b10 : 2'b01;
                    state_d  = ORDER;
                end
            end
            ORDER: state_d = EXEC;
            EXEC:  state_d = RESP;
            RESP: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, magnitude ordering and result registration.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            id_q       <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            out_data   <= FP12_ZERO;
            out_id     <= 1'b0;
            out_ovf    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        x_q        <= sel_a;
                        y_q        <= sel_b;
                        id_q       <= win_id;
                        last_grant <= win_id;
                    end
                end
                ORDER: begin
                    if (y_q > x_q) begin
                        x_q <= y_q;
                        y_q <= x_q;
                    end
                end
                EXEC: begin
                    out_data <= res_data;
                    out_ovf  <= res_ovf;
                    out_id   <= id_q;
                end
                default: ;
            endcase
        end
    end

`ifdef FP12_ARB_STATS_EN
    // Completion and overflow tallies, advanced once per delivered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_done0 <= 8'd0;
            cnt_done1 <= 8'd0;
            cnt_ovf   <= 8'd0;
        end else if (out_valid && out_ready) begin
            if (out_id) begin
                cnt_done1 <= cnt_done1 + 8'd1;
            end else begin
                cnt_done0 <= cnt_done0 + 8'd1;
            end
            if (out_ovf) begin
                cnt_ovf <= cnt_ovf + 8'd1;
            end
        end
    end
`endif

endmodule
